// File: rtl/pwm_note_sequencer_ctrl.sv
// Note-sequence controller: steps through a writable {note, len} pattern memory at a
// programmable tempo. Optional staccato gap enabled by defining NOTE_GAP_EN.
module pwm_note_sequencer_ctrl #(
    parameter int unsigned       DEPTH      = 16,
    parameter int unsigned       AW         = 4,
    parameter int unsigned       NOTE_W     = 6,
    parameter logic [NOTE_W-1:0] REST_NOTE  = '0,
    parameter int unsigned       GAP_CYCLES = 256
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [NOTE_W+3:0] i_wr_data,
    input  logic [31:0]       i_unit_period,
    input  logic [AW-1:0]     i_last_addr,
    input  logic              i_loop,
    input  logic              i_play,
    input  logic              i_pause,
    input  logic              i_stop,
    output logic [NOTE_W-1:0] o_note,
    output logic              o_note_strobe,
    output logic [AW-1:0]     o_index,
    output logic              o_playing,
    output logic              o_done
);

    typedef enum logic [1:0] {StIdle, StPlay, StPause} state_e;

    state_e            r_state, w_state_next;

    logic [NOTE_W+3:0] r_mem [DEPTH];
    logic [NOTE_W-1:0] r_note;
    logic [3:0]        r_len;
    logic [3:0]        r_len_cnt;
    logic [31:0]       r_unit;
    logic [AW-1:0]     r_index;
    logic              r_strobe;
    logic              r_done;

    logic [31:0]       w_period;
    logic              w_unit_end;
    logic              w_note_end;
    logic              w_at_last;
    logic              w_start;
    logic              w_advance;
    logic              w_finish;
    logic              w_gap;
    logic [AW-1:0]     w_next_index;
    logic [NOTE_W+3:0] w_next_entry;
    logic [NOTE_W+3:0] w_first_entry;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign w_period      = (i_unit_period == 32'd0) ? 32'd1 : i_unit_period;
    assign w_unit_end    = (r_unit >= w_period - 32'd1);
    // len 0 wraps to 15 here, giving the 16-unit note
    assign w_note_end    = w_unit_end && (r_len_cnt == r_len - 4'd1);
    assign w_at_last     = (r_index == i_last_addr);
    assign w_next_index  = w_at_last ? '0 : r_index + AW'(1);
    assign w_next_entry  = r_mem[w_next_index];
    assign w_first_entry = r_mem[0];

    assign w_start   = (r_state == StIdle) && (w_state_next == StPlay);
    // The cycle a pause is taken is frozen, so it never counts toward the note length
    assign w_advance = (r_state == StPlay) && (w_state_next == StPlay);
    assign w_finish  = (r_state == StPlay) && (w_state_next == StIdle) && !i_stop;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (!i_stop && i_play) w_state_next = StPlay;
            end
            StPlay: begin
                if (i_stop) begin
                    w_state_next = StIdle;
                end else if (i_pause) begin
                    w_state_next = StPause;
                end else if (w_note_end && w_at_last && !i_loop) begin
                    w_state_next = StIdle;
                end
            end
            StPause: begin
                if (i_stop) begin
                    w_state_next = StIdle;
                end else if (i_play) begin
                    w_state_next = StPlay;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_note    <= REST_NOTE;
            r_len     <= 4'd0;
            r_len_cnt <= 4'd0;
            r_unit    <= 32'd0;
            r_index   <= '0;
            r_strobe  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_done   <= w_finish;
            if (w_start) begin
                r_index   <= '0;
                r_note    <= w_first_entry[NOTE_W+3:4];
                r_len     <= w_first_entry[3:0];
                r_unit    <= 32'd0;
                r_len_cnt <= 4'd0;
                r_strobe  <= 1'b1;
            end else if (w_state_next == StIdle) begin
                r_index   <= '0;
                r_unit    <= 32'd0;
                r_len_cnt <= 4'd0;
            end else if (w_advance) begin
                if (w_note_end) begin
                    r_index   <= w_next_index;
                    r_note    <= w_next_entry[NOTE_W+3:4];
                    r_len     <= w_next_entry[3:0];
                    r_unit    <= 32'd0;
                    r_len_cnt <= 4'd0;
                    r_strobe  <= 1'b1;
                end else if (w_unit_end) begin
                    r_unit    <= 32'd0;
                    r_len_cnt <= r_len_cnt + 4'd1;
                end else begin
                    r_unit    <= r_unit + 32'd1;
                end
            end
        end
    end

`ifdef NOTE_GAP_EN
    logic [36:0] w_units;
    logic [36:0] w_total;
    logic [36:0] w_remain;
    logic [36:0] w_gap_len;

    assign w_units   = (r_len == 4'd0) ? 37'd16 : 37'(r_len);
    assign w_total   = w_units * 37'(w_period);
    // Cycles of the current note still to come after this one
    assign w_remain  = (w_units - 37'd1 - 37'(r_len_cnt)) * 37'(w_period)
                     + 37'(w_period - 32'd1 - r_unit);
    assign w_gap_len = (37'(GAP_CYCLES) < w_total - 37'd1) ? 37'(GAP_CYCLES)
                                                           : w_total - 37'd1;
    assign w_gap     = (w_remain < w_gap_len);
`else
    // GAP_CYCLES only matters when the gap is built in
    assign w_gap = 1'b0 & (GAP_CYCLES != 0);
`endif

    always_comb begin
        o_note = REST_NOTE;
        if (r_state == StPlay && !w_gap) begin
            o_note = r_note;
        end
        o_note_strobe = r_strobe;
        o_index       = r_index;
        o_playing     = (r_state == StPlay);
        o_done        = r_done;
    end

endmodule

// File: tb/tb_pwm_note_sequencer_ctrl.sv
// Self-checking bench for pwm_note_sequencer_ctrl: directed scenarios plus randomized
// play/pause/stop/write traffic against a cycle-level reference model.
module tb_pwm_note_sequencer_ctrl;

    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [9:0]  wr_data = '0;
    logic [31:0] period = 32'd10;
    logic [3:0]  last = '0;
    logic        loop = 1'b0;
    logic        play = 1'b0;
    logic        pause = 1'b0;
    logic        stop = 1'b0;
    logic [5:0]  note;
    logic        strobe;
    logic [3:0]  index;
    logic        playing;
    logic        done;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state
    logic [9:0] m_mem [16];
    int         m_state;    // 0 idle, 1 play, 2 pause
    int         m_idx;
    int         m_elapsed;
    int         m_dur;
    logic [5:0] m_note;
    logic       m_strobe;
    logic       m_done;

    pwm_note_sequencer_ctrl #(
        .DEPTH      (16),
        .AW         (4),
        .NOTE_W     (6),
        .REST_NOTE  (6'd0),
        .GAP_CYCLES (GAP)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_wr_en       (wr_en),
        .i_wr_addr     (wr_addr),
        .i_wr_data     (wr_data),
        .i_unit_period (period),
        .i_last_addr   (last),
        .i_loop        (loop),
        .i_play        (play),
        .i_pause       (pause),
        .i_stop        (stop),
        .o_note        (note),
        .o_note_strobe (strobe),
        .o_index       (index),
        .o_playing     (playing),
        .o_done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Expected sounding code at cycle offset off of a note lasting dur cycles
    function automatic logic [5:0] exp_code(input logic [5:0] code, input int off, input int dur);
`ifdef NOTE_GAP_EN
        int g;
        g = (GAP < dur - 1) ? GAP : dur - 1;
        if (dur - 1 - off < g) return 6'd0;
`endif
        return code;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input int n, input int l);
        wr_en = 1'b1;
        wr_addr = 4'(a);
        wr_data = {6'(n), 4'(l)};
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_play();
        play = 1'b1;
        tick();
        play = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        play = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({note, strobe, index, playing, done} !== 13'd0) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %h expected 0",
                         i, {note, strobe, index, playing, done});
            end
        end
        rst = 1'b0;
        play = 1'b0;
        tick();
        n_checks++;
        if ({note, strobe, index, playing, done} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected 0", {note, strobe, index, playing, done});
        end
    endtask

    task automatic test_sequence(input bit lp);
        int st, dur;
        logic [5:0] code;
        logic [3:0] idx;
        logic on, dn;
        logic [12:0] exp;
        write_entry(0, 5, 2);
        write_entry(1, 9, 1);
        period = 32'd10;
        last = 4'd1;
        loop = lp;
        pulse_play();
        for (int c = 1; c <= 35; c++) begin
            on = 1'b1; dn = 1'b0; st = 1; dur = 1; code = 6'd0; idx = 4'd0;
            if (c <= 20) begin
                st = 1; dur = 20; code = 6'd5; idx = 4'd0;
            end else if (c <= 30) begin
                st = 21; dur = 10; code = 6'd9; idx = 4'd1;
            end else if (lp) begin
                st = 31; dur = 20; code = 6'd5; idx = 4'd0;
            end else begin
                on = 1'b0; dn = (c == 31);
            end
            exp = on ? {exp_code(code, c - st, dur), (c == st), idx, 1'b1, 1'b0}
                     : {6'd0, 1'b0, 4'd0, 1'b0, dn};
            n_checks++;
            if ({note, strobe, index, playing, done} !== exp) begin
                n_fail++;
                $display("FAIL sequence loop=%0d cycle %0d: got %h expected %h",
                         lp, c, {note, strobe, index, playing, done}, exp);
            end
            tick();
        end
        if (lp) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
            n_checks++;
            if ({note, strobe, index, playing, done} !== 13'd0) begin
                n_fail++;
                $display("FAIL loop_stop: got %h expected 0", {note, strobe, index, playing, done});
            end
        end
    endtask

    task automatic test_long_len();
        int first_done, strobes;
        logic [5:0] n1;
        // Pass 0: len 0 (16 units) at P=4; pass 1: len 3 at P=0 (treated as 1)
        for (int pass = 0; pass < 2; pass++) begin
            write_entry(0, pass ? 3 : 7, pass ? 3 : 0);
            last = 4'd0;
            loop = 1'b0;
            period = pass ? 32'd0 : 32'd4;
            pulse_play();
            first_done = -1;
            strobes = 0;
            n1 = 6'd0;
            for (int t = 1; t <= 80 && first_done < 0; t++) begin
                if (strobe) strobes++;
                if (t == 1) n1 = note;
                if (done) first_done = t;
                else tick();
            end
            n_checks++;
            if (first_done != (pass ? 4 : 65)) begin
                n_fail++;
                $display("FAIL note_length pass %0d: done at %0d expected %0d",
                         pass, first_done, pass ? 4 : 65);
            end
            n_checks++;
            if (strobes != 1 || n1 !== (pass ? 6'd3 : 6'd7)) begin
                n_fail++;
                $display("FAIL note_length_strobe pass %0d: strobes %0d note %0d expected 1 and %0d",
                         pass, strobes, n1, pass ? 3 : 7);
            end
            tick();
        end
    endtask

    task automatic test_pause();
        int first;
        write_entry(0, 11, 2);
        write_entry(1, 12, 1);
        period = 32'd10;
        last = 4'd1;
        loop = 1'b0;
        pulse_play();
        repeat (7) tick();
        pause = 1'b1;
        tick();
        pause = 1'b0;
        n_checks++;
        if ({note, strobe, playing} !== 8'd0 || index !== 4'd0) begin
            n_fail++;
            $display("FAIL pause_enter: got note %0d strobe %0d playing %0d idx %0d expected 0s",
                     note, strobe, playing, index);
        end
        repeat (49) tick();
        n_checks++;
        if ({note, playing} !== 7'd0) begin
            n_fail++;
            $display("FAIL pause_hold: got note %0d playing %0d expected 0", note, playing);
        end
        play = 1'b1;
        tick();
        play = 1'b0;
        n_checks++;
        if ({strobe, playing} !== 2'b01 || note !== exp_code(6'd11, 7, 20) || index !== 4'd0) begin
            n_fail++;
            $display("FAIL resume: got strobe %0d playing %0d note %0d idx %0d expected 0 1 %0d 0",
                     strobe, playing, note, index, exp_code(6'd11, 7, 20));
        end
        first = -1;
        for (int r = 1; r <= 30 && first < 0; r++) begin
            if (strobe) first = r;
            else tick();
        end
        n_checks++;
        if (first != 14 || index !== 4'd1 || note !== 6'd12) begin
            n_fail++;
            $display("FAIL resume_end: strobe at %0d idx %0d note %0d expected 14 1 12",
                     first, index, note);
        end
        for (int k = 0; k < 2; k++) begin
            stop = 1'b1;
            play = 1'b1;
            tick();
            stop = 1'b0;
            play = 1'b0;
            n_checks++;
            if ({note, strobe, index, playing, done} !== 13'd0) begin
                n_fail++;
                $display("FAIL stop_play_same_cycle %0d: got %h expected 0",
                         k, {note, strobe, index, playing, done});
            end
        end
    endtask

    task automatic test_gap();
        int dur;
        write_entry(0, 6, 1);
        last = 4'd0;
        loop = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            period = pass ? 32'd3 : 32'd10;
            dur = pass ? 3 : 10;
            pulse_play();
            for (int c = 0; c < dur; c++) begin
                n_checks++;
                if ({note, playing} !== {exp_code(6'd6, c, dur), 1'b1}) begin
                    n_fail++;
                    $display("FAIL gap dur %0d offset %0d: got note %0d playing %0d expected %0d 1",
                             dur, c, note, playing, exp_code(6'd6, c, dur));
                end
                tick();
            end
            n_checks++;
            if ({done, playing, note} !== {1'b1, 1'b0, 6'd0}) begin
                n_fail++;
                $display("FAIL gap_end dur %0d: got done %0d playing %0d note %0d expected 1 0 0",
                         dur, done, playing, note);
            end
            tick();
        end
    endtask

    task automatic m_start(input int i, input int p);
        logic [9:0] e;
        e = m_mem[i];
        m_idx = i;
        m_note = e[9:4];
        m_dur = ((e[3:0] == 4'd0) ? 16 : int'(e[3:0])) * p;
        m_elapsed = 0;
        m_strobe = 1'b1;
        m_state = 1;
    endtask

    task automatic model_step();
        int p;
        m_strobe = 1'b0;
        m_done = 1'b0;
        p = (period == 32'd0) ? 1 : int'(period);
        case (m_state)
            0: if (play && !stop) m_start(0, p);
            1: begin
                if (stop) begin
                    m_state = 0; m_idx = 0;
                end else if (pause) begin
                    m_state = 2;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == m_dur) begin
                        if (m_idx == int'(last)) begin
                            if (loop) m_start(0, p);
                            else begin
                                m_state = 0; m_idx = 0; m_done = 1'b1;
                            end
                        end else begin
                            m_start((m_idx + 1) % 16, p);
                        end
                    end
                end
            end
            default: begin
                if (stop) begin
                    m_state = 0; m_idx = 0;
                end else if (play) begin
                    m_state = 1;
                end
            end
        endcase
        if (wr_en) m_mem[wr_addr] = wr_data;
    endtask

    task automatic test_random();
        logic [5:0] en;
        logic [12:0] exp;
        for (int a = 0; a < 16; a++) begin
            m_mem[a] = 10'($urandom);
            write_entry(a, int'(m_mem[a][9:4]), int'(m_mem[a][3:0]));
        end
        for (int ep = 0; ep < 4; ep++) begin
            {stop, pause, play, wr_en} = 4'b1000;
            tick();
            stop = 1'b0;
            period = 32'($urandom_range(0, 3));
            last = 4'($urandom_range(0, 3));
            loop = 1'($urandom);
            m_state = 0; m_idx = 0; m_strobe = 1'b0; m_done = 1'b0;
            m_elapsed = 0; m_dur = 1; m_note = 6'd0;
            for (int cyc = 0; cyc < 500; cyc++) begin
                stop = ($urandom_range(0, 79) == 0);
                pause = ($urandom_range(0, 39) == 0);
                play = ($urandom_range(0, 14) == 0);
                wr_en = ($urandom_range(0, 3) == 0);
                wr_addr = 4'($urandom);
                wr_data = 10'($urandom);
                if ($urandom_range(0, 49) == 0) last = 4'($urandom);
                if ($urandom_range(0, 49) == 0) loop = 1'($urandom);
                @(posedge clk);
                model_step();
                #1;
                en = (m_state == 1) ? exp_code(m_note, m_elapsed, m_dur) : 6'd0;
                exp = {en, m_strobe, 4'(m_idx), (m_state == 1), m_done};
                n_checks++;
                if ({note, strobe, index, playing, done} !== exp) begin
                    n_fail++;
                    $display("FAIL random ep %0d cycle %0d: got %h expected %h",
                             ep, cyc, {note, strobe, index, playing, done}, exp);
                end
            end
        end
        {stop, pause, play, wr_en} = 4'b1000;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_reset_mid();
        period = 32'd10;
        pulse_play();
        tick();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({note, strobe, index, playing, done} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_mid_note: got %h expected 0", {note, strobe, index, playing, done});
        end
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({note, strobe, index, playing, done} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_mid_after: got %h expected 0", {note, strobe, index, playing, done});
        end
    endtask

    initial begin
        test_reset();
        test_sequence(1'b0);
        test_sequence(1'b1);
        test_long_len();
        test_pause();
        test_gap();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
